// File: rtl/clk_step_ctrl.sv
// Run/single-step controller for the processor clock divider: debounced STEP/RUN
// buttons drive the divider enable, and every stop lands just after a falling edge of the divided clock.
module clk_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_step,
  input  logic               btn_run,
  input  logic               halt,
  input  logic               clk_div_in,
  output logic               en,
  output logic               running,
  output logic               busy,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HALT,
    S_STEP_RISE,
    S_STEP_FALL,
    S_RUN,
    S_DRAIN
  } state_e;

  // Button bit 0 is STEP, bit 1 is RUN.
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           level_q, level_d;
  logic [1:0]           prev_q, prev_d;
  logic [1:0]           pulse_q, pulse_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

  logic                 div_q, div_d;
  logic                 div_rise, div_fall;

  state_e               state_q, state_d;
  logic                 en_q, en_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic                 step_pulse, run_pulse;

  assign step_pulse = pulse_q[0];
  assign run_pulse  = pulse_q[1];
  assign div_rise   = clk_div_in & ~div_q;
  assign div_fall   = ~clk_div_in & div_q;

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    sync1_d  = {btn_run, btn_step};
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      // Counter only advances while the synchronised level disagrees with the accepted one.
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          level_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
        end
      end
    end
    prev_d  = level_q;
    pulse_d = level_q & ~prev_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT: begin
        if (run_pulse) begin
          state_d = S_RUN;
        end else if (step_pulse) begin
          state_d = S_STEP_RISE;
        end
      end
      S_STEP_RISE: if (div_rise) state_d = S_STEP_FALL;
      S_STEP_FALL: if (div_fall) state_d = S_HALT;
      S_RUN:       if (run_pulse || halt) state_d = S_DRAIN;
      S_DRAIN:     if (div_fall) state_d = S_HALT;
      default:     state_d = S_HALT;
    endcase

    // Enable is decoded from the next state so it drops on the same edge that sees the fall.
    en_d  = (state_d != S_HALT);
    div_d = clk_div_in;

    count_d = count_q;
    if (div_rise && (state_q != S_HALT)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
      db_cnt_q <= '0;
      div_q    <= 1'b0;
      state_q  <= S_HALT;
      en_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      prev_q   <= prev_d;
      pulse_q  <= pulse_d;
      db_cnt_q <= db_cnt_d;
      div_q    <= div_d;
      state_q  <= state_d;
      en_q     <= en_d;
      count_q  <= count_d;
    end
  end

  assign en          = en_q;
  assign running     = (state_q == S_RUN);
  assign busy        = (state_q != S_HALT);
  assign cycle_count = count_q;

endmodule
